ram_arbiter: RTL
================

# ram_arbiter

Two-port arbiter sharing the single word-wide RAM port between two requesters: requester 0 (boot/preload writer, e.g. constant-table loader) and requester 1 (datapath/cache side). It sequences one RAM transaction at a time through the `ramstate` handshake, holds the grant until `ACCESS` or `ERROR`, and flags stalled transactions with a timeout. It sits between the requesters and the RAM model, in the cache level of the top block.

## Interface
Parameters:
- TIMEOUT, 255, cycles a granted transaction may wait for ACCESS/ERROR before it is aborted (1..255)

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous reset, active low
- req0_ren / req0_wen  in  1  requester 0 read / write request
- req0_addr / req0_store  in  32  requester 0 byte address / write data
- req0_load  out  32  read data to requester 0
- req0_wait  out  1  requester 0 must hold its request
- req1_ren, req1_wen, req1_addr, req1_store, req1_load, req1_wait  same as requester 0
- ram_ren / ram_wen  out  1  RAM read / write enable
- ram_addr / ram_store  out  32  RAM address / write data
- ram_load  in  32  RAM read data
- ram_state  in  ramstate_t  FREE, BUSY, ACCESS, ERROR
- arb_err  out  1  one-cycle pulse: ERROR response or timeout

## Operation
- States: ARB_IDLE, ARB_GNT0, ARB_GNT1.
- reqN is active when reqN_ren or reqN_wen is high.
- ARB_IDLE: all ram_* outputs 0. If exactly one requester is active, go to its GNT state. If both are active, use the priority rule (see Configuration). If neither is active, stay.
- ARB_GNTn:
  - Drive ram_addr and ram_store from requester n.
  - Drive ram_wen = reqn_wen and ram_ren = reqn_ren & ~reqn_wen; write wins if both are set.
  - Drive reqn_load = ram_load. The non-granted load output is 0.
- Completion: in GNTn with ram_state == ACCESS, reqn_wait = 0 for that cycle and the next state is ARB_IDLE. Re-arbitration always costs one IDLE cycle.
- ram_state == ERROR in GNTn: treated as completion. reqn_wait = 0, arb_err = 1 for one cycle, next state ARB_IDLE.
- Withdrawal: if requester n drops both ren and wen while in GNTn, ram_ren and ram_wen go 0 combinationally and the next state is ARB_IDLE. No error is raised.
- Timeout:
  - An 8-bit wait counter clears on entry to GNTn and increments each GNTn cycle without ACCESS or ERROR.
  - When the counter reaches TIMEOUT: arb_err pulses, reqn_wait = 0, next state ARB_IDLE. The requester sees completion with undefined load data.
- reqN_wait = reqN active & ~(granted to N & completing this cycle). It is combinational and is 1 for a non-granted active requester.

## Timing
- Reset values: state ARB_IDLE, counter 0, last_grant = 1, so requester 0 wins the first tie.
- Outputs during reset: ram_ren, ram_wen, ram_addr, ram_store, both load outputs and arb_err are all 0. reqN_wait equals reqN active.
- Latency: a request seen in IDLE in cycle t is granted in cycle t+1. With ram_state == ACCESS in t+1, the requester completes in t+1. Minimum is 2 cycles per transaction and 1 dead cycle between back-to-back grants.
- Requesters must hold addr, data and enables stable while reqN_wait = 1.
- Reset asserted mid-transaction: state returns to ARB_IDLE immediately and RAM enables drop asynchronously. The transaction is lost with no error.
- Simultaneous ACCESS and timeout in the same cycle: ACCESS wins, and arb_err stays 0.

## Configuration
- RAM_ARB_RR_EN defined:
  - Round-robin. On a tie, grant the requester that was not last_grant.
  - last_grant updates on every entry to a GNT state.
- RAM_ARB_RR_EN undefined:
  - Fixed priority. Requester 0 always wins a tie.
  - last_grant is not implemented.

## Structure
- cpu_types_pkg holds:
  - `arb_state_t` (ARB_IDLE, ARB_GNT0, ARB_GNT1)
  - existing `ramstate_t` and `word_t`
  - `ARB_TIMEOUT_DEFAULT = 8'd255`
- Sub-module `ram_arb_pick` is the combinational tie-break chooser.
  - Inputs: req0/req1 active, last_grant.
  - Outputs: grant0, grant1.
  - Its RR logic is under RAM_ARB_RR_EN.
- FSM, timeout counter and muxing live in ram_arbiter.

## Test plan
- Reset, no requests -> ram_ren = ram_wen = 0, arb_err = 0, both wait = 0, state ARB_IDLE.
- req0 write, addr 0x00000004, store 0x71374491, ram_state ACCESS at grant -> ram_wen = 1 in cycle 2, ram_addr = 0x4, req0_wait low in cycle 2, IDLE in cycle 3.
- Both request continuously with RAM always ACCESS:
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: only requester 0 is served while req0 is held.
  - req1_wait stays 1 whenever requester 1 is not granted.
- req1 read at 0x00000100, RAM BUSY 3 cycles then ACCESS with ram_load = 0xdeadbeef -> req1_load = 0xdeadbeef on the ACCESS cycle, req1_wait low only then.
- Timeout:
  - Setup: TIMEOUT = 4, RAM held BUSY.
  - Expected: arb_err pulses on the 4th grant cycle, req0_wait drops, and the arbiter returns to IDLE.
  - Variant: ram_state = ERROR instead gives the same pulse at once.
- nRST low while in ARB_GNT1 -> ram_ren and ram_wen drop immediately and the arbiter is in ARB_IDLE after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the cache-level RAM arbiter.
// Holds the word, RAM handshake and arbiter state types plus the arbiter timeout default.
package cpu_types_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned ARB_CNT_W = 8;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    // One requester's view of a RAM transaction
    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
    } ram_req_t;

    localparam logic [ARB_CNT_W-1:0] ARB_TIMEOUT_DEFAULT = 8'd255;

    function automatic logic req_active(input ram_req_t r);
        return r.ren | r.wen;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM model.
// slave = arbiter view, master = requester/RAM-model view.
interface ram_arbiter_if;
    import cpu_types_pkg::*;

    logic      req0_ren;
    logic      req0_wen;
    word_t     req0_addr;
    word_t     req0_store;
    word_t     req0_load;
    logic      req0_wait;

    logic      req1_ren;
    logic      req1_wen;
    word_t     req1_addr;
    word_t     req1_store;
    word_t     req1_load;
    logic      req1_wait;

    logic      ram_ren;
    logic      ram_wen;
    word_t     ram_addr;
    word_t     ram_store;
    word_t     ram_load;
    ramstate_t ram_state;

    logic      arb_err;

    modport slave (
        input  req0_ren, req0_wen, req0_addr, req0_store,
        input  req1_ren, req1_wen, req1_addr, req1_store,
        input  ram_load, ram_state,
        output req0_load, req0_wait, req1_load, req1_wait,
        output ram_ren, ram_wen, ram_addr, ram_store,
        output arb_err
    );

    modport master (
        output req0_ren, req0_wen, req0_addr, req0_store,
        output req1_ren, req1_wen, req1_addr, req1_store,
        output ram_load, ram_state,
        input  req0_load, req0_wait, req1_load, req1_wait,
        input  ram_ren, ram_wen, ram_addr, ram_store,
        input  arb_err
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational tie-break chooser for the two RAM requesters.
// Round-robin on last_grant when RAM_ARB_RR_EN is defined, fixed priority to requester 0 otherwise.
module ram_arb_pick (
    input  logic i_req0_act,
    input  logic i_req1_act,
`ifdef RAM_ARB_RR_EN
    input  logic i_last_grant,
`endif
    output logic o_grant0,
    output logic o_grant1
);

`ifdef RAM_ARB_RR_EN
    // On a tie the requester that was not served last time wins
    always_comb begin
        o_grant0 = i_req0_act & (~i_req1_act |  i_last_grant);
        o_grant1 = i_req1_act & (~i_req0_act | ~i_last_grant);
    end
`else
    always_comb begin
        o_grant0 = i_req0_act;
        o_grant1 = i_req1_act & ~i_req0_act;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single word-wide RAM port, one transaction at a time.
// Optional round-robin tie-break under RAM_ARB_RR_EN; default build is fixed priority to requester 0.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter logic [ARB_CNT_W-1:0] TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);

    localparam logic [ARB_CNT_W-1:0] TMO_LAST = TIMEOUT - ARB_CNT_W'(1);

    arb_state_t           r_state;
    logic [ARB_CNT_W-1:0] r_cnt;
`ifdef RAM_ARB_RR_EN
    logic                 r_last_grant;
`endif

    ram_req_t w_req0;
    ram_req_t w_req1;
    ram_req_t w_sel;
    logic     w_act0;
    logic     w_act1;
    logic     w_pick0;
    logic     w_pick1;
    logic     w_gnt0;
    logic     w_gnt1;
    logic     w_gnt_any;
    logic     w_sel_act;
    logic     w_resp;
    logic     w_tmo;
    logic     w_done;

    always_comb begin
        w_req0 = '{ren: bus.req0_ren, wen: bus.req0_wen, addr: bus.req0_addr, store: bus.req0_store};
        w_req1 = '{ren: bus.req1_ren, wen: bus.req1_wen, addr: bus.req1_addr, store: bus.req1_store};
        w_act0 = req_active(w_req0);
        w_act1 = req_active(w_req1);
    end

    ram_arb_pick u_pick (
        .i_req0_act   (w_act0),
        .i_req1_act   (w_act1),
`ifdef RAM_ARB_RR_EN
        .i_last_grant (r_last_grant),
`endif
        .o_grant0     (w_pick0),
        .o_grant1     (w_pick1)
    );

    // Completion decode: ACCESS/ERROR response, timeout, or the owner withdrawing
    always_comb begin
        w_gnt0    = (r_state == ARB_GNT0);
        w_gnt1    = (r_state == ARB_GNT1);
        w_gnt_any = w_gnt0 | w_gnt1;
        w_sel     = w_gnt1 ? w_req1 : w_req0;
        w_sel_act = (w_gnt0 & w_act0) | (w_gnt1 & w_act1);
        w_resp    = (bus.ram_state == ACCESS) | (bus.ram_state == ERROR);
        w_tmo     = w_gnt_any & ~w_resp & (r_cnt == TMO_LAST);
        w_done    = w_gnt_any & (~w_sel_act | w_resp | w_tmo);
    end

    // RAM-side and requester-side muxing; all zero outside a grant
    always_comb begin
        bus.ram_ren   = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_store = '0;
        bus.req0_load = '0;
        bus.req1_load = '0;
        bus.arb_err   = 1'b0;

        if (w_gnt_any) begin
            bus.ram_wen   = w_sel.wen;
            bus.ram_ren   = w_sel.ren & ~w_sel.wen;
            bus.ram_addr  = w_sel.addr;
            bus.ram_store = w_sel.store;
            bus.arb_err   = w_sel_act & ((bus.ram_state == ERROR) | w_tmo);
        end

        if (w_gnt0) begin
            bus.req0_load = bus.ram_load;
        end
        if (w_gnt1) begin
            bus.req1_load = bus.ram_load;
        end

        bus.req0_wait = w_act0 & ~(w_gnt0 & w_done);
        bus.req1_wait = w_act1 & ~(w_gnt1 & w_done);
    end

    // Grant FSM with wait counter; every completion returns through one IDLE cycle
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= ARB_IDLE;
            r_cnt        <= '0;
`ifdef RAM_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick0) begin
                        r_state      <= ARB_GNT0;
                        r_cnt        <= '0;
`ifdef RAM_ARB_RR_EN
                        r_last_grant <= 1'b0;
`endif
                    end else if (w_pick1) begin
                        r_state      <= ARB_GNT1;
                        r_cnt        <= '0;
`ifdef RAM_ARB_RR_EN
                        r_last_grant <= 1'b1;
`endif
                    end
                end
                ARB_GNT0, ARB_GNT1: begin
                    if (w_done) begin
                        r_state <= ARB_IDLE;
                    end else begin
                        r_cnt <= r_cnt + ARB_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
